// File: rtl/cv32e41p_obi_mem_bridge.sv
// OBI data-port to single-port synchronous SRAM bridge with fixed response latency.
// Optional address range check: define CV32E41P_MEM_BRIDGE_RANGE_CHECK_EN.
module cv32e41p_obi_mem_bridge #(
    parameter int unsigned MEM_WORDS       = 16384,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RESP_LAT        = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned AW             = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          data_req_i,
    output logic          data_gnt_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    input  logic          stall_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    logic [2:0]          cnt_q, cnt_d;
    logic [RESP_LAT-1:0] vld_q, vld_d;
    logic                zero_q, zero_d;
    logic                in_range;
    logic [31:0]         rsp_data;

`ifdef CV32E41P_MEM_BRIDGE_RANGE_CHECK_EN
    assign in_range = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    logic unused_lo;
    assign unused_lo = ^{data_addr_i[1:0], BASE_ADDR[AW+1:0]};
`else
    // Upper address bits alias into the SRAM window.
    assign in_range = 1'b1;
    logic unused_addr;
    assign unused_addr = ^{data_addr_i[31:AW+2], data_addr_i[1:0], BASE_ADDR};
`endif

    assign data_rvalid_o = vld_q[RESP_LAT-1];
    // A response leaving this cycle frees a slot, so the limit can be met at full rate.
    assign data_gnt_o    = rst_ni & data_req_i & ~stall_i &
                           ((cnt_q < 3'(MAX_OUTSTANDING)) | data_rvalid_o);

    always_comb begin
        mem_req_o   = data_gnt_o & in_range;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i[AW+1:2];
            mem_wdata_o = data_wdata_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({data_gnt_o, data_rvalid_o})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        vld_d[0] = data_gnt_o;
        for (int i = 1; i < RESP_LAT; i++) vld_d[i] = vld_q[i-1];
        // Writes and dropped accesses answer with zero instead of SRAM data.
        zero_d = data_we_i | ~mem_req_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= 3'd0;
            vld_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            zero_q <= zero_d;
        end
    end

    if (RESP_LAT == 1) begin : g_lat1
        assign rsp_data = zero_q ? 32'h0 : mem_rdata_i;
    end else begin : g_latn
        // SRAM data is valid one cycle after grant, so it joins the entry leaving stage 0.
        logic [RESP_LAT-2:0][31:0] data_q, data_d;

        always_comb begin
            data_d[0] = zero_q ? 32'h0 : mem_rdata_i;
            for (int i = 1; i < RESP_LAT - 1; i++) data_d[i] = data_q[i-1];
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) data_q <= '0;
            else         data_q <= data_d;
        end

        assign rsp_data = data_q[RESP_LAT-2];
    end

    assign data_rdata_o = data_rvalid_o ? rsp_data : 32'h0;

endmodule

// File: tb/tb_cv32e41p_obi_mem_bridge.sv
// Bench for cv32e41p_obi_mem_bridge: instance 0 has RESP_LAT=1, instance 1 has RESP_LAT=3.
module tb_cv32e41p_obi_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, we, stall;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    int          sel;

    logic [1:0]       gnt_w, rvalid_w, mreq_w, mwe_w;
    logic [1:0][31:0] rdata_w, mwdata_w, mrdata_w;
    logic [1:0][3:0]  mbe_w;
    logic [1:0][9:0]  maddr_w;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int rv_cnt [2];

    always @(posedge clk) cyc <= cyc + 1;

    cv32e41p_obi_mem_bridge #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req & (sel == 0)), .data_gnt_o(gnt_w[0]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid_w[0]), .data_rdata_o(rdata_w[0]), .stall_i(stall),
        .mem_req_o(mreq_w[0]), .mem_we_o(mwe_w[0]), .mem_be_o(mbe_w[0]), .mem_addr_o(maddr_w[0]),
        .mem_wdata_o(mwdata_w[0]), .mem_rdata_i(mrdata_w[0]));

    cv32e41p_obi_mem_bridge #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LAT(3), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req & (sel == 1)), .data_gnt_o(gnt_w[1]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid_w[1]), .data_rdata_o(rdata_w[1]), .stall_i(stall),
        .mem_req_o(mreq_w[1]), .mem_we_o(mwe_w[1]), .mem_be_o(mbe_w[1]), .mem_addr_o(maddr_w[1]),
        .mem_wdata_o(mwdata_w[1]), .mem_rdata_i(mrdata_w[1]));

    // SRAM models, one-cycle read latency
    logic [31:0] mem0 [0:1023] = '{default: '0};
    logic [31:0] mem1 [0:1023] = '{default: '0};

    always @(posedge clk) begin
        if (mreq_w[0]) begin
            if (mwe_w[0]) for (int b = 0; b < 4; b++) if (mbe_w[0][b]) mem0[maddr_w[0]][b*8 +: 8] <= mwdata_w[0][b*8 +: 8];
            mrdata_w[0] <= mem0[maddr_w[0]];
        end
    end

    always @(posedge clk) begin
        if (mreq_w[1]) begin
            if (mwe_w[1]) for (int b = 0; b < 4; b++) if (mbe_w[1][b]) mem1[maddr_w[1]][b*8 +: 8] <= mwdata_w[1][b*8 +: 8];
            mrdata_w[1] <= mem1[maddr_w[1]];
        end
    end

    // Scoreboard: reference memory, expected response queued at grant
    typedef struct {
        int          dut;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] ref_mem [2][1024];

    always @(negedge clk) begin
        exp_t        e;
        logic [9:0]  idx;
        logic        hit;
        for (int d = 0; d < 2; d++) if (rvalid_w[d]) rv_cnt[d]++;
        if (!rst_n) sbq.delete();
        else begin
            for (int d = 0; d < 2; d++) begin
                if (rvalid_w[d]) begin
                    tests_run++;
                    if (sbq.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected dut%0d: rvalid at cyc %0d with nothing expected", d, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.dut !== d || e.data !== rdata_w[d] || e.cyc !== cyc) begin
                            fails++;
                            $display("FAIL sb_resp dut%0d: got data %h cyc %0d, want dut%0d data %h cyc %0d",
                                     d, rdata_w[d], cyc, e.dut, e.data, e.cyc);
                        end
                    end
                end
                if (gnt_w[d]) begin
                    idx = addr[11:2];
`ifdef CV32E41P_MEM_BRIDGE_RANGE_CHECK_EN
                    hit = (addr[31:12] == 20'h0);
`else
                    hit = 1'b1;
`endif
                    e.dut = d;
                    e.cyc = cyc + ((d == 0) ? 1 : 3);
                    if (we) begin
                        if (hit) for (int b = 0; b < 4; b++) if (be[b]) ref_mem[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
                        e.data = 32'h0;
                    end else begin
                        e.data = hit ? ref_mem[d][idx] : 32'h0;
                    end
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, output int gc, output logic mr);
        req = 1'b1; we = w; addr = a; wdata = wd; be = b; gc = -1; mr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt_w[sel]) begin
                gc = cyc;
                mr = mreq_w[sel];
                break;
            end
        end
        if (gc < 0) begin
            tests_run++; fails++;
            $display("FAIL issue_timeout dut%0d: no grant for addr %h within 50 cycles", sel, a);
        end else if (mr) begin
            tests_run++;
            if (maddr_w[sel] !== a[11:2]) begin
                fails++;
                $display("FAIL mem_addr dut%0d: got %h, want %h", sel, maddr_w[sel], a[11:2]);
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h100; be = 4'hF;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            @(negedge clk);
            tests_run += 4;
            if (gnt_w[d] !== 1'b0)        begin fails++; $display("FAIL reset_gnt dut%0d: got %b, want 0", d, gnt_w[d]); end
            if (mreq_w[d] !== 1'b0)       begin fails++; $display("FAIL reset_mem_req dut%0d: got %b, want 0", d, mreq_w[d]); end
            if (rvalid_w[d] !== 1'b0)     begin fails++; $display("FAIL reset_rvalid dut%0d: got %b, want 0", d, rvalid_w[d]); end
            if (rdata_w[d] !== 32'h0)     begin fails++; $display("FAIL reset_rdata dut%0d: got %h, want 0", d, rdata_w[d]); end
        end
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int g0, g1; logic mr;
        sel = 0;
        issue(1'b1, 32'h100, 32'h1234_5678, 4'hF, g0, mr);
        issue(1'b0, 32'h100, 32'h0, 4'hF, g1, mr);
        tests_run++;
        if (g1 !== g0 + 1) begin fails++; $display("FAIL b2b_grant: second grant at %0d, want %0d", g1, g0 + 1); end
        drain();
    endtask

    task automatic test_byte_enables();
        int g; logic mr;
        sel = 0;
        issue(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, g, mr);
        issue(1'b1, 32'h40, 32'h0000_00AA, 4'b0001, g, mr);
        issue(1'b0, 32'h40, 32'h0, 4'hF, g, mr);
        drain();
    endtask

    task automatic test_outstanding();
        int g [4]; logic mr;
        sel = 1;
        issue(1'b1, 32'h100, 32'hCAFE_0001, 4'hF, g[0], mr);
        issue(1'b1, 32'h104, 32'hCAFE_0002, 4'hF, g[1], mr);
        drain();
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, g[i], mr);
        tests_run += 3;
        if (g[1] !== g[0] + 1) begin fails++; $display("FAIL limit_g1: got %0d, want %0d", g[1], g[0] + 1); end
        if (g[2] !== g[0] + 3) begin fails++; $display("FAIL limit_g2: got %0d, want %0d", g[2], g[0] + 3); end
        if (g[3] !== g[0] + 4) begin fails++; $display("FAIL limit_g3: got %0d, want %0d", g[3], g[0] + 4); end
        drain();
    endtask

    task automatic test_stall();
        int g; logic mr;
        sel = 1;
        issue(1'b0, 32'h100, 32'h0, 4'hF, g, mr);
        stall = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h104; be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run += 2;
            if (gnt_w[1] !== 1'b0)  begin fails++; $display("FAIL stall_gnt cycle %0d: got %b, want 0", i, gnt_w[1]); end
            if (mreq_w[1] !== 1'b0) begin fails++; $display("FAIL stall_mem_req cycle %0d: got %b, want 0", i, mreq_w[1]); end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (gnt_w[1] !== 1'b1) begin fails++; $display("FAIL stall_release_gnt: got %b, want 1", gnt_w[1]); end
        @(posedge clk); #1;
        req = 1'b0;
        drain();
    endtask

    task automatic test_reset_midflight();
        int g, rv0; logic mr;
        sel = 1;
        issue(1'b0, 32'h104, 32'h0, 4'hF, g, mr);
        rst_n = 1'b0;
        rv0 = rv_cnt[1];
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();
        tests_run += 2;
        if (rv_cnt[1] !== rv0)      begin fails++; $display("FAIL midflight_rvalid: got %0d responses, want 0", rv_cnt[1] - rv0); end
        if (u_dut_b.cnt_q !== 3'd0) begin fails++; $display("FAIL midflight_cnt: got %0d, want 0", u_dut_b.cnt_q); end
        issue(1'b0, 32'h104, 32'h0, 4'hF, g, mr);
        drain();
    endtask

    task automatic test_out_of_range();
        int g; logic mr;
        sel = 0;
        issue(1'b1, 32'h0, 32'h1111_1111, 4'hF, g, mr);
        issue(1'b1, 32'h1000, 32'h5A5A_5A5A, 4'hF, g, mr);
        tests_run++;
`ifdef CV32E41P_MEM_BRIDGE_RANGE_CHECK_EN
        if (mr !== 1'b0) begin fails++; $display("FAIL oor_mem_req: got %b, want 0", mr); end
`else
        if (mr !== 1'b1) begin fails++; $display("FAIL oor_mem_req: got %b, want 1", mr); end
`endif
        issue(1'b0, 32'h1000, 32'h0, 4'hF, g, mr);
        issue(1'b0, 32'h0, 32'h0, 4'hF, g, mr);
        drain();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; stall = 1'b0; be = 4'h0;
        addr = 32'h0; wdata = 32'h0; sel = 0;
        rv_cnt[0] = 0; rv_cnt[1] = 0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) ref_mem[d][i] = 32'h0;
        test_reset();
        test_back_to_back();
        test_byte_enables();
        test_outstanding();
        test_stall();
        test_reset_midflight();
        test_out_of_range();
        tests_run++;
        if (sbq.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d responses never arrived", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
